txc_epl_sched: RTL and testbench
================================

// Module: txc_epl_sched
// PURPOSE
//  Transmit-side segment scheduler between the EPB read path and the four EPL ports.
//  Picks at most one segment per cycle from the per-port EPL queues.
//  Policy: weighted round robin, packet-locked, with per-port EPL credit tracking.
//  Output is a registered one-hot grant that the TXC uses to issue one EPB segment read.
// PARAMETERS
//  N_PORTS   4   number of EPL requesters (gnt_port width = $clog2(N_PORTS))
//  CRED_W    6   width of each per-port credit counter
//  CRED_INIT 32  credit counter value after reset (must be < 2**CRED_W)
//  WGT_W     4   width of each per-port weight (segments per turn)
// PORTS
//  clk          in   1              core clock
//  rst          in   1              synchronous reset, active high
//  cfg_weight   in   N_PORTS*WGT_W  per-port quantum in segments; 0 is treated as 1
//  req          in   N_PORTS        port i has a head segment ready
//  req_eop      in   N_PORTS        head segment of port i is EOP (valid only with req[i])
//  crd_ret      in   N_PORTS        EPL i returns one credit (one per cycle per port)
//  gnt          out  N_PORTS        one-hot registered grant; all zero = no grant
//  gnt_vld      out  1              |gnt
//  gnt_port     out  $clog2(N)      encoded index of gnt; 0 when gnt_vld=0
//  gnt_eop      out  1              granted segment was EOP
//  crd_cnt      out  N_PORTS*CRED_W current credit counters
//  crd_err      out  1              sticky credit overflow, cleared only by rst
// BEHAVIOUR
//  - Clock and reset: one clock (clk); rst is synchronous and active high.
//  - Reset values: gnt=0, gnt_vld=0, gnt_port=0, gnt_eop=0, crd_err=0, crd_cnt[i]=CRED_INIT.
//    Reset state: FSM=ARB, rr_ptr=0, quantum=0, lock_port=0.
//  - Eligibility: elig[i] = req[i] & (crd_cnt[i]!=0). A port with zero credit is never granted.
//  - Latency: the decision uses this cycle's req, req_eop and crd_cnt. gnt/gnt_port/gnt_eop appear
//    on the next clk edge; the credit decrement lands on that same edge.
//  - FSM state ARB (no owner):
//    - Grant the first elig port scanning rr_ptr, rr_ptr+1, ... modulo N (rr_ptr inclusive).
//    - Set lock_port = granted port; quantum = max(weight,1) - 1.
//    - Non-EOP grant -> PKT.
//    - EOP grant with quantum>0 -> HOLD.
//    - EOP grant with quantum==0 -> rr_ptr = port+1 (mod N), stay in ARB.
//    - No elig port -> no grant, rr_ptr unchanged.
//  - FSM state PKT (mid-packet): only lock_port may be granted.
//    - If it is not elig: stall with no grant and keep state. Other ports are NOT served.
//    - Each grant decrements quantum, saturating at 0.
//    - EOP grant -> HOLD if quantum>0, else ARB with rr_ptr = lock_port+1.
//  - FSM state HOLD (between packets, quantum remaining):
//    - lock_port elig: grant it; next state and quantum as in PKT.
//    - lock_port not elig: no grant this cycle; -> ARB with rr_ptr = lock_port+1.
//  - Credits, per port and per cycle:
//    - grant only -> cnt-1. crd_ret only -> cnt+1. Both -> unchanged.
//    - crd_ret when cnt==2**CRED_W-1 and no grant -> cnt holds at max and crd_err is set.
//    - A grant is never issued at cnt==0, so underflow cannot occur.
//  - Weight changes: cfg_weight is sampled only when quantum is loaded in ARB. A change
//    mid-turn takes effect at that port's next turn.
//  - Reset mid-packet: lock is dropped, credits return to CRED_INIT, and no grant is
//    issued in the cycle after rst is deasserted unless ARB selects one.
//  - gnt is always one-hot or zero. gnt_eop = req_eop[port] captured with the grant.
// TESTING
//  1. All weights 1, req=4'b1111, all req_eop=1, credits ample
//     -> grants rotate 0,1,2,3,0; one grant per cycle; first grant on cycle 1 after rst deasserts.
//  2. Weight[0]=3, other weights 1, all ports requesting single-segment packets
//     -> grant sequence 0,0,0,1,2,3,0,0,0.
//  3. Port 1 sends a 4-segment packet (EOP on the 4th) while port 2 is also requesting
//     -> 1,1,1,1 with no port-2 grant until port 1's EOP; then port 2 is granted.
//  4. CRED_INIT=2, port 0 only, no crd_ret
//     -> two grants, then stall with crd_cnt[0]=0; one crd_ret pulse gives exactly one more grant.
//  5. crd_cnt[3]=63 (CRED_W=6), crd_ret[3]=1, no grant
//     -> cnt stays 63 and crd_err=1 until rst; grant and crd_ret in the same cycle leave cnt unchanged.
//  6. rst asserted while in PKT on port 2
//     -> next cycle gnt=0, all crd_cnt=32, ARB from rr_ptr=0.

Source files
------------

// File: rtl/txc_epl_sched.sv
// Transmit-side EPL segment scheduler: packet-locked weighted round robin
// over N_PORTS requesters with per-port credit counters and a registered
// one-hot grant.
module txc_epl_sched #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned CRED_W    = 6,
  parameter int unsigned CRED_INIT = 32,
  parameter int unsigned WGT_W     = 4,
  localparam int unsigned PW       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS*WGT_W-1:0]    cfg_weight,
  input  logic [N_PORTS-1:0]          req,
  input  logic [N_PORTS-1:0]          req_eop,
  input  logic [N_PORTS-1:0]          crd_ret,
  output logic [N_PORTS-1:0]          gnt,
  output logic                        gnt_vld,
  output logic [PW-1:0]               gnt_port,
  output logic                        gnt_eop,
  output logic [N_PORTS*CRED_W-1:0]   crd_cnt,
  output logic                        crd_err
);

  typedef enum logic [1:0] {StArb, StPkt, StHold} state_e;

  localparam logic [CRED_W-1:0] CredMax  = {CRED_W{1'b1}};
  localparam logic [CRED_W-1:0] CredRst  = CRED_W'(CRED_INIT);

  state_e              state_q, state_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [PW-1:0]       lock_q, lock_d;
  logic [WGT_W-1:0]    quant_q, quant_d;
  logic [N_PORTS-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]       gnt_port_q, gnt_port_d;
  logic                gnt_eop_q, gnt_eop_d;
  logic                gnt_vld_d;
  logic                crd_err_q, crd_err_d;
  logic [CRED_W-1:0]   crd_q [N_PORTS];
  logic [CRED_W-1:0]   crd_d [N_PORTS];

  logic [N_PORTS-1:0]  elig;
  logic                arb_found;
  logic [PW-1:0]       arb_sel;
  logic [WGT_W-1:0]    arb_wgt;
  logic [WGT_W-1:0]    quant_dec;

  // Modulo-N increment of a port index.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    return PW'(s % N_PORTS);
  endfunction

  // Eligibility: requesting and holding at least one credit.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      elig[i] = req[i] & (crd_q[i] != '0);
    end
  end

  // Round-robin search starting at rr_q (inclusive).
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!arb_found && elig[wrap_add(rr_q, k)]) begin
        arb_found = 1'b1;
        arb_sel   = wrap_add(rr_q, k);
      end
    end
    arb_wgt   = cfg_weight[arb_sel*WGT_W +: WGT_W];
    quant_dec = (quant_q == '0) ? '0 : quant_q - WGT_W'(1);
  end

  // Scheduler next-state: grant choice, lock, quantum and pointer update.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    quant_d    = quant_q;
    gnt_vld_d  = 1'b0;
    gnt_port_d = '0;
    gnt_eop_d  = 1'b0;
    case (state_q)
      StArb: begin
        if (arb_found) begin
          gnt_vld_d  = 1'b1;
          gnt_port_d = arb_sel;
          gnt_eop_d  = req_eop[arb_sel];
          lock_d     = arb_sel;
          // A zero weight still buys one segment per turn.
          quant_d    = (arb_wgt == '0) ? '0 : arb_wgt - WGT_W'(1);
          if (!req_eop[arb_sel]) begin
            state_d = StPkt;
          end else if (quant_d != '0) begin
            state_d = StHold;
          end else begin
            rr_d = wrap_add(arb_sel, 1);
          end
        end
      end
      StPkt, StHold: begin
        if (elig[lock_q]) begin
          gnt_vld_d  = 1'b1;
          gnt_port_d = lock_q;
          gnt_eop_d  = req_eop[lock_q];
          quant_d    = quant_dec;
          if (!req_eop[lock_q]) begin
            state_d = StPkt;
          end else if (quant_dec != '0) begin
            state_d = StHold;
          end else begin
            state_d = StArb;
            rr_d    = wrap_add(lock_q, 1);
          end
        end else if (state_q == StHold) begin
          // Owner has nothing to send between packets: give up the rest of the turn.
          state_d = StArb;
          rr_d    = wrap_add(lock_q, 1);
        end
      end
      default: state_d = StArb;
    endcase
    gnt_d = gnt_vld_d ? (N_PORTS'(1) << gnt_port_d) : '0;
  end

  // Credit counters: grant consumes, return refills, overflow is sticky.
  always_comb begin
    crd_err_d = crd_err_q;
    for (int i = 0; i < N_PORTS; i++) begin
      crd_d[i] = crd_q[i];
      if (crd_ret[i] && !gnt_d[i]) begin
        if (crd_q[i] == CredMax) begin
          crd_err_d = 1'b1;
        end else begin
          crd_d[i] = crd_q[i] + CRED_W'(1);
        end
      end else if (gnt_d[i] && !crd_ret[i]) begin
        crd_d[i] = crd_q[i] - CRED_W'(1);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StArb;
      rr_q       <= '0;
      lock_q     <= '0;
      quant_q    <= '0;
      gnt_q      <= '0;
      gnt_port_q <= '0;
      gnt_eop_q  <= 1'b0;
      crd_err_q  <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
        crd_q[i] <= CredRst;
      end
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      quant_q    <= quant_d;
      gnt_q      <= gnt_d;
      gnt_port_q <= gnt_port_d;
      gnt_eop_q  <= gnt_eop_d;
      crd_err_q  <= crd_err_d;
      for (int i = 0; i < N_PORTS; i++) begin
        crd_q[i] <= crd_d[i];
      end
    end
  end

  // Output packing.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      crd_cnt[i*CRED_W +: CRED_W] = crd_q[i];
    end
  end

  assign gnt      = gnt_q;
  assign gnt_vld  = |gnt_q;
  assign gnt_port = gnt_port_q;
  assign gnt_eop  = gnt_eop_q;
  assign crd_err  = crd_err_q;

endmodule

// File: tb/tb_txc_epl_sched.sv
// Directed bench for txc_epl_sched: rotation, weights, packet lock, credit
// exhaustion/overflow and reset mid-packet.
module tb_txc_epl_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_weight;
  logic [3:0]  req;
  logic [3:0]  req_eop;
  logic [3:0]  crd_ret;
  logic [3:0]  gnt;
  logic        gnt_vld;
  logic [1:0]  gnt_port;
  logic        gnt_eop;
  logic [23:0] crd_cnt;
  logic        crd_err;

  int checks   = 0;
  int failures = 0;

  txc_epl_sched dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_weight (cfg_weight),
    .req        (req),
    .req_eop    (req_eop),
    .crd_ret    (crd_ret),
    .gnt        (gnt),
    .gnt_vld    (gnt_vld),
    .gnt_port   (gnt_port),
    .gnt_eop    (gnt_eop),
    .crd_cnt    (crd_cnt),
    .crd_err    (crd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // p < 0 means no grant expected.
  task automatic exp_g(input string tag, input int p);
    chk({tag, ".gnt"}, 32'(gnt), (p < 0) ? 32'd0 : (32'd1 << p));
    chk({tag, ".vld"}, 32'(gnt_vld), (p < 0) ? 32'd0 : 32'd1);
    chk({tag, ".port"}, 32'(gnt_port), (p < 0) ? 32'd0 : 32'(p));
  endtask

  task automatic exp_crd(input string tag, input int port, input int val);
    chk(tag, 32'(crd_cnt[6*port +: 6]), 32'(val));
  endtask

  int exp2[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};

  initial begin
    rst = 1'b1; cfg_weight = 16'h1111; req = '0; req_eop = '0; crd_ret = '0;
    @(negedge clk);
    step(); step();

    // Reset values
    exp_g("rst", -1);
    chk("rst.eop", 32'(gnt_eop), 32'd0);
    chk("rst.err", 32'(crd_err), 32'd0);
    chk("rst.crd", 32'(crd_cnt), 32'({4{6'd32}}));

    // 1: equal weights, all single-segment requests rotate
    rst = 1'b0; req = 4'b1111; req_eop = 4'b1111;
    step(); exp_g("t1.g0", 0); chk("t1.eop", 32'(gnt_eop), 32'd1);
    step(); exp_g("t1.g1", 1);
    step(); exp_g("t1.g2", 2);
    step(); exp_g("t1.g3", 3);
    step(); exp_g("t1.g4", 0);
    exp_crd("t1.crd0", 0, 30);
    exp_crd("t1.crd1", 1, 31);
    exp_crd("t1.crd3", 3, 31);
    req = '0;
    step(); exp_g("t1.idle", -1);

    // 2: weight[0]=3
    rst = 1'b1; step(); exp_g("t2.rst", -1);
    rst = 1'b0; cfg_weight = 16'h1113; req = 4'b1111; req_eop = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      step(); exp_g($sformatf("t2.g%0d", i), exp2[i]);
    end
    exp_crd("t2.crd0", 0, 26);
    exp_crd("t2.crd2", 2, 31);
    req = '0;
    step(); exp_g("t2.idle", -1);

    // 3: 4-segment packet on port 1 locks out port 2 (rr is at 1)
    cfg_weight = 16'h1111; req = 4'b0110; req_eop = 4'b0000;
    step(); exp_g("t3.s1", 1); chk("t3.s1eop", 32'(gnt_eop), 32'd0);
    req = 4'b0100;
    step(); exp_g("t3.stall", -1);
    req = 4'b0110;
    step(); exp_g("t3.s2", 1);
    step(); exp_g("t3.s3", 1);
    req_eop = 4'b0010;
    step(); exp_g("t3.s4", 1); chk("t3.s4eop", 32'(gnt_eop), 32'd1);
    req_eop = 4'b0110;
    step(); exp_g("t3.p2", 2);
    exp_crd("t3.crd1", 1, 27);
    req = '0;
    step(); exp_g("t3.idle", -1);

    // 4: drain port 0 credits, then one return buys one grant
    rst = 1'b1; step();
    rst = 1'b0; req = 4'b0001; req_eop = 4'b0001;
    for (int i = 0; i < 32; i++) begin
      step(); exp_g($sformatf("t4.g%0d", i), 0);
    end
    exp_crd("t4.crd0", 0, 0);
    step(); exp_g("t4.stall0", -1);
    crd_ret = 4'b0001;
    step(); exp_g("t4.stall1", -1); exp_crd("t4.ret", 0, 1);
    crd_ret = '0;
    step(); exp_g("t4.extra", 0); exp_crd("t4.crd0b", 0, 0);
    step(); exp_g("t4.stall2", -1);
    req = '0;

    // 5: saturate port 3 credits and flag overflow
    crd_ret = 4'b1000;
    for (int i = 0; i < 31; i++) step();
    exp_crd("t5.full", 3, 63);
    chk("t5.noerr", 32'(crd_err), 32'd0);
    step();
    exp_crd("t5.sat", 3, 63);
    chk("t5.err", 32'(crd_err), 32'd1);
    crd_ret = '0;
    step(); chk("t5.sticky", 32'(crd_err), 32'd1);
    req = 4'b1000; req_eop = 4'b1000; crd_ret = 4'b1000;
    step(); exp_g("t5.g3", 3); exp_crd("t5.both", 3, 63);
    req = '0; crd_ret = '0;
    step(); exp_g("t5.idle", -1);
    req = 4'b1000;
    step(); exp_g("t5.g3b", 3); exp_crd("t5.dec", 3, 62);
    chk("t5.sticky2", 32'(crd_err), 32'd1);
    req = '0;

    // 6: reset while port 2 holds the packet lock
    rst = 1'b1; step();
    chk("t6.errclr", 32'(crd_err), 32'd0);
    rst = 1'b0; req = 4'b0100; req_eop = 4'b0000;
    step(); exp_g("t6.s1", 2);
    step(); exp_g("t6.s2", 2);
    rst = 1'b1;
    step(); exp_g("t6.rst", -1);
    chk("t6.crd", 32'(crd_cnt), 32'({4{6'd32}}));
    rst = 1'b0; req = 4'b0011; req_eop = 4'b0011;
    step(); exp_g("t6.arb0", 0);
    step(); exp_g("t6.arb1", 1);
    req = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
